// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-issue datapath: FETCH/DECODE/EXEC/MEM/WB sequencing,
// slow-memory handshake with timeout, retired-instruction counter and sticky illegal flag.
module mc_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Option,
   input  logic [5:0]       Function,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic [1:0]       Regdst,
   output logic             Branch0,
   output logic             Branch1,
   output logic             Branch2,
   output logic             MemRead,
   output logic             MemWrite,
   output logic [1:0]       MemtoReg,
   output logic [2:0]       ALUOp,
   output logic             ALUSrc,
   output logic             Regwrite,
   output logic [1:0]       Sign,
   output logic [2:0]       state_o,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [5:0] OP_R   = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2b, OP_BEQ = 6'h04, OP_J   = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;

   typedef enum logic [2:0] {
      FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5
   } state_t;

   state_t          state, next;
   logic [5:0]      op_q, fn_q;
   logic [WW-1:0]   wait_cnt;
   logic            is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
   logic            is_beq, is_j, is_jal, is_flow, is_ralu;
   logic            legal_in, wait_last, timeout, retire;
   logic [2:0]      alu_op;
   logic            alu_src;
   logic [1:0]      sign_sel;
   logic            unused_zero;

   // Zero steers the datapath's PC select directly; sequencing never needs it.
   assign unused_zero = Zero;

   function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_R:                                         legal = (fn == FN_ADDU) || (fn == FN_SUBU) || (fn == FN_JR);
         OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
   endfunction

   assign legal_in = legal(Option, Function);
   assign is_r     = (op_q == OP_R);
   assign is_addu  = is_r && (fn_q == FN_ADDU);
   assign is_subu  = is_r && (fn_q == FN_SUBU);
   assign is_jr    = is_r && (fn_q == FN_JR);
   assign is_ori   = (op_q == OP_ORI);
   assign is_lui   = (op_q == OP_LUI);
   assign is_lw    = (op_q == OP_LW);
   assign is_sw    = (op_q == OP_SW);
   assign is_beq   = (op_q == OP_BEQ);
   assign is_j     = (op_q == OP_J);
   assign is_jal   = (op_q == OP_JAL);
   assign is_flow  = is_beq || is_j || is_jal || is_jr;
   assign is_ralu  = is_addu || is_subu;

   assign wait_last = (wait_cnt == WW'(MEM_TIMEOUT - 1));
   assign timeout   = (state == MEM) && !mem_ready && wait_last;
   assign retire    = ((state == EXEC) && is_flow) || ((state == MEM) && is_sw && mem_ready) ||
                      (state == WB);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         FETCH:  next = DECODE;
         DECODE: next = legal_in ? EXEC : HALT;
         EXEC: begin
            if (is_lw || is_sw) next = MEM;
            else if (is_flow)   next = FETCH;
            else                next = WB;
         end
         MEM: begin
            if (mem_ready)      next = is_lw ? WB : FETCH;
            else if (wait_last) next = HALT;
         end
         WB:      next = FETCH;
         HALT:    next = HALT;
         default: next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q        <= '0;
         fn_q        <= '0;
         wait_cnt    <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         if (state == DECODE) begin
            op_q <= Option;
            fn_q <= Function;
         end
         wait_cnt <= (state == MEM) ? wait_cnt + WW'(1) : '0;
         if (((state == DECODE) && !legal_in) || timeout) illegal <= 1'b1;
         if (retire) instr_count <= instr_count + CNT_W'(1);
      end
   end

   always_comb begin
      alu_op   = 3'b000;
      alu_src  = 1'b0;
      sign_sel = 2'd0;
      if (is_subu || is_beq) alu_op = 3'b001;
      if (is_beq) sign_sel = 2'd1;
      if (is_ori) begin
         alu_op  = 3'b010;
         alu_src = 1'b1;
      end
      if (is_lui) begin
         alu_op   = 3'b011;
         alu_src  = 1'b1;
         sign_sel = 2'd2;
      end
      if (is_lw || is_sw) begin
         alu_src  = 1'b1;
         sign_sel = 2'd1;
      end
   end

   // ALU controls stay up through MEM/WB so a datapath without an ALUOut latch still sees a stable result.
   always_comb begin
      PCWrite  = 1'b0; IRWrite  = 1'b0; Regdst   = 2'd0; Branch0 = 1'b0; Branch1 = 1'b0;
      Branch2  = 1'b0; MemRead  = 1'b0; MemWrite = 1'b0; MemtoReg = 2'd0; ALUOp  = 3'b000;
      ALUSrc   = 1'b0; Regwrite = 1'b0; Sign     = 2'd0;
      if (reset) begin
         case (state)
            FETCH: IRWrite = 1'b1;
            EXEC: begin
               ALUOp   = alu_op;
               ALUSrc  = alu_src;
               Sign    = sign_sel;
               PCWrite = is_flow;
               Branch0 = is_beq;
               Branch1 = is_j || is_jal;
               Branch2 = is_jr;
               if (is_jal) begin
                  Regwrite = 1'b1;
                  Regdst   = 2'd2;
                  MemtoReg = 2'd2;
               end
            end
            MEM: begin
               ALUOp    = alu_op;
               ALUSrc   = alu_src;
               Sign     = sign_sel;
               MemRead  = is_lw;
               MemWrite = is_sw;
               // sw's single PC update has to land on its completing MEM cycle.
               PCWrite  = is_sw && mem_ready;
            end
            WB: begin
               ALUOp    = alu_op;
               ALUSrc   = alu_src;
               Sign     = sign_sel;
               Regwrite = 1'b1;
               PCWrite  = 1'b1;
               Regdst   = is_ralu ? 2'd1 : 2'd0;
               MemtoReg = is_lw ? 2'd1 : 2'd0;
            end
            default: ;
         endcase
      end
   end

   assign state_o = state;

endmodule
